// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory with a req/ack
// handshake, returning a one-cycle ready pulse and read data to the granted port.
module mem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_ready_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    dm_ready_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ack_i,
  output logic                    stall_if_o,
  output logic                    stall_mem_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  owner_t     owner;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       fetch_wins;

  // Data normally wins; fetch only gets in once the data streak is exhausted.
  assign fetch_wins  = if_req_i & (~dm_req_i | (streak == STREAK_MAX));
  assign stall_if_o  = if_req_i & ~if_ready_o;
  assign stall_mem_o = dm_req_i & ~dm_ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      streak      <= '0;
      tcnt        <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      if_ready_o  <= 1'b0;
      dm_ready_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins.
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      err_o      <= 1'b0;

      case (state)
        IDLE: begin
          if (if_req_i || dm_req_i) begin
            state     <= BUSY;
            mem_req_o <= 1'b1;
            tcnt      <= '0;
            if (fetch_wins) begin
              owner       <= OWN_IF;
              mem_we_o    <= 1'b0;
              mem_be_o    <= '1;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              streak      <= '0;
            end else begin
              owner       <= OWN_DM;
              mem_we_o    <= dm_we_i;
              mem_be_o    <= dm_be_i;
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              if (!if_req_i)
                streak <= '0;
              else if (streak >= STREAK_MAX)
                streak <= STREAK_MAX;
              else
                streak <= streak + 4'd1;
            end
          end
        end

        BUSY: begin
          if (mem_ack_i || tcnt == TCNT_LAST) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            err_o     <= ~mem_ack_i;
            if (owner == OWN_IF) begin
              if_ready_o <= 1'b1;
              if (mem_ack_i)
                if_rdata_o <= mem_rdata_i;
            end else begin
              dm_ready_o <= 1'b1;
              if (mem_ack_i && !mem_we_o)
                dm_rdata_o <= mem_rdata_i;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: handshake latency, arbitration, data
// streak limit, wait states, timeout and asynchronous reset.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ready_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [3:0]    dm_be_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ready_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;
  logic          stall_if_o;
  logic          stall_mem_o;
  logic          err_o;

  int compared   = 0;
  int mismatched = 0;
  int if_pulses  = 0;
  int dm_pulses  = 0;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DM_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_ready_o) if_pulses++;
    if (dm_ready_o) dm_pulses++;
  end

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    cyc(); cyc();
    compared++;
    if ({mem_req_o, if_ready_o, dm_ready_o, err_o, mem_we_o} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got req/ifr/dmr/err/we=%b want 00000",
               {mem_req_o, if_ready_o, dm_ready_o, err_o, mem_we_o});
    end
    compared++;
    if ({if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_data: got if_rdata=%h dm_rdata=%h addr=%h wdata=%h be=%b want all 0",
               if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single_fetch();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    compared++;
    if (stall_if_o !== 1'b1) begin mismatched++; $display("FAIL fetch_stall_c0: got %b want 1", stall_if_o); end
    cyc();
    mem_ack_i = 1'b1;
    #1;
    compared++;
    if ({mem_req_o, mem_we_o, mem_be_o, stall_if_o, if_ready_o} !== {1'b1, 1'b0, 4'hF, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL fetch_c1_ctrl: got req/we/be/stall/rdy=%b want 1011111 0", {mem_req_o, mem_we_o, mem_be_o, stall_if_o, if_ready_o});
    end
    compared++;
    if (mem_addr_o !== 32'h0000_0010) begin mismatched++; $display("FAIL fetch_c1_addr: got %h want 00000010", mem_addr_o); end
    cyc();
    mem_ack_i = 1'b0;
    #1;
    compared++;
    if ({if_ready_o, stall_if_o, mem_req_o} !== 3'b100) begin
      mismatched++;
      $display("FAIL fetch_c2_ctrl: got rdy/stall/req=%b want 100", {if_ready_o, stall_if_o, mem_req_o});
    end
    compared++;
    if (if_rdata_o !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL fetch_c2_rdata: got %h want deadbeef", if_rdata_o); end
    if_req_i = 1'b0;
    cyc();
    #1;
    compared++;
    if (if_ready_o !== 1'b0) begin mismatched++; $display("FAIL fetch_c3_rdy: got %b want 0", if_ready_o); end
  endtask

  task automatic test_arbitration();
    int if0, dm0;
    if0 = if_pulses; dm0 = dm_pulses;
    if_req_i = 1'b1; if_addr_i = 32'h40;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h100; dm_wdata_i = '0;
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
    #1;
    compared++;
    if (mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin
      mismatched++; $display("FAIL arb_first_grant: got addr=%h we=%b want 00000100 0", mem_addr_o, mem_we_o);
    end
    cyc();
    mem_ack_i = 1'b0;
    #1;
    compared++;
    if ({dm_ready_o, if_ready_o, stall_mem_o, stall_if_o} !== 4'b1001 || dm_rdata_o !== 32'hAAAA_5555) begin
      mismatched++;
      $display("FAIL arb_dm_resp: got dmr/ifr/stm/sti=%b rdata=%h want 1001 aaaa5555",
               {dm_ready_o, if_ready_o, stall_mem_o, stall_if_o}, dm_rdata_o);
    end
    dm_req_i = 1'b0;
    cyc();
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    #1;
    compared++;
    if (mem_addr_o !== 32'h40 || mem_req_o !== 1'b1) begin
      mismatched++; $display("FAIL arb_second_grant: got addr=%h req=%b want 00000040 1", mem_addr_o, mem_req_o);
    end
    cyc();
    mem_ack_i = 1'b0;
    #1;
    compared++;
    if (if_ready_o !== 1'b1 || if_rdata_o !== 32'h1111_2222) begin
      mismatched++; $display("FAIL arb_if_resp: got rdy=%b rdata=%h want 1 11112222", if_ready_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    cyc();
    compared++;
    if (if_pulses - if0 !== 1 || dm_pulses - dm0 !== 1) begin
      mismatched++; $display("FAIL arb_pulse_count: got if=%0d dm=%0d want 1 1", if_pulses - if0, dm_pulses - dm0);
    end
  endtask

  task automatic test_streak();
    int if0, dm0;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_streak;
    if0 = if_pulses; dm0 = dm_pulses;
    if_req_i = 1'b1; if_addr_i = 32'h80;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h200;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp_addr   = (i < 4) ? 32'h200 : 32'h80;
      exp_streak = (i < 4) ? 4'(i + 1) : 4'd0;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A_0000 + 32'(i);
      #1;
      compared++;
      if (mem_addr_o !== exp_addr || dut.streak !== exp_streak) begin
        mismatched++;
        $display("FAIL streak_grant_%0d: got addr=%h streak=%0d want %h %0d", i, mem_addr_o, dut.streak, exp_addr, exp_streak);
      end
      cyc();
      mem_ack_i = 1'b0;
      if (i == 4) begin if_req_i = 1'b0; dm_req_i = 1'b0; end
      cyc();
    end
    compared++;
    if (dm_pulses - dm0 !== 4 || if_pulses - if0 !== 1) begin
      mismatched++; $display("FAIL streak_pulses: got dm=%0d if=%0d want 4 1", dm_pulses - dm0, if_pulses - if0);
    end
  endtask

  task automatic test_write_wait();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_addr_i = 32'h300;
    dm_wdata_i = 32'h1234_5678; mem_rdata_i = 32'hFFFF_0000;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 3) mem_ack_i = 1'b1;
      #1;
      compared++;
      if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b110011 || mem_wdata_o !== 32'h1234_5678 ||
          mem_addr_o !== 32'h300 || dm_ready_o !== 1'b0) begin
        mismatched++;
        $display("FAIL write_busy_c%0d: got req/we/be=%b wdata=%h addr=%h rdy=%b want 110011 12345678 00000300 0",
                 c, {mem_req_o, mem_we_o, mem_be_o}, mem_wdata_o, mem_addr_o, dm_ready_o);
      end
    end
    cyc();
    mem_ack_i = 1'b0;
    #1;
    compared++;
    if (dm_ready_o !== 1'b1 || mem_req_o !== 1'b0 || dm_rdata_o !== 32'h5A5A_0003) begin
      mismatched++;
      $display("FAIL write_resp: got rdy=%b req=%b rdata=%h want 1 0 5a5a0003", dm_ready_o, mem_req_o, dm_rdata_o);
    end
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    if_req_i = 1'b1; if_addr_i = 32'h500; mem_ack_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      #1;
      compared++;
      if ({mem_req_o, err_o, if_ready_o} !== 3'b100) begin
        mismatched++; $display("FAIL timeout_busy_c%0d: got req/err/rdy=%b want 100", c, {mem_req_o, err_o, if_ready_o});
      end
    end
    cyc();
    #1;
    compared++;
    if ({mem_req_o, err_o, if_ready_o} !== 3'b011 || if_rdata_o !== 32'h5A5A_0004) begin
      mismatched++;
      $display("FAIL timeout_c9: got req/err/rdy=%b rdata=%h want 011 5a5a0004", {mem_req_o, err_o, if_ready_o}, if_rdata_o);
    end
    if_req_i = 1'b0;
    cyc();
    #1;
    compared++;
    if ({mem_req_o, err_o, if_ready_o} !== 3'b000) begin
      mismatched++; $display("FAIL timeout_c10: got req/err/rdy=%b want 000", {mem_req_o, err_o, if_ready_o});
    end
  endtask

  task automatic test_idle_ack();
    mem_ack_i = 1'b1;
    cyc();
    cyc();
    #1;
    compared++;
    if ({mem_req_o, if_ready_o, dm_ready_o, err_o} !== 4'b0000) begin
      mismatched++; $display("FAIL idle_ack: got req/ifr/dmr/err=%b want 0000", {mem_req_o, if_ready_o, dm_ready_o, err_o});
    end
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int if0, dm0;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h600;
    cyc();
    compared++;
    if (mem_req_o !== 1'b1) begin mismatched++; $display("FAIL rstmid_busy: got req=%b want 1", mem_req_o); end
    if0 = if_pulses; dm0 = dm_pulses;
    rst = 1'b0;
    #1;
    compared++;
    if ({mem_req_o, dm_ready_o, err_o} !== 3'b000 || dm_rdata_o !== '0 || mem_addr_o !== '0) begin
      mismatched++;
      $display("FAIL rstmid_async: got req/rdy/err=%b rdata=%h addr=%h want 000 0 0",
               {mem_req_o, dm_ready_o, err_o}, dm_rdata_o, mem_addr_o);
    end
    dm_req_i = 1'b0; mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    compared++;
    if (if_pulses != if0 || dm_pulses != dm0 || err_o !== 1'b0) begin
      mismatched++; $display("FAIL rstmid_no_resp: got if=%0d dm=%0d err=%b want 0 0 0", if_pulses - if0, dm_pulses - dm0, err_o);
    end
    if_req_i = 1'b1; if_addr_i = 32'h700; mem_rdata_i = 32'hCAFE_F00D;
    cyc();
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0;
    #1;
    compared++;
    if (if_ready_o !== 1'b1 || if_rdata_o !== 32'hCAFE_F00D) begin
      mismatched++; $display("FAIL rstmid_fresh_fetch: got rdy=%b rdata=%h want 1 cafef00d", if_ready_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_arbitration();
    test_streak();
    test_write_wait();
    test_timeout();
    test_idle_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
